alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU: next generation of the combinational ALU. Adds real MUL/DIV
//  (iterative), variable shift/rotate amounts, registered flags and a valid/ready handshake.
//  Sits between decode/issue and writeback; one operation in flight, output held until taken.
// PARAMETERS
//  N        32            operand/result width (>=8, power of two)
//  SHAMT_W  $clog2(N)     shift-amount width, taken from b[SHAMT_W-1:0]
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        reset, asynchronous, active-low
//  in_valid   in   1        operation offered
//  in_ready   out  1        block accepts operation this cycle
//  op         in   5        opcode (alu_pkg::alu_op_e)
//  a, b       in   N        operands
//  cin        in   1        carry-in, ADD only
//  out_valid  out  1        result/flags valid
//  out_ready  in   1        consumer takes result
//  result     out  N        primary result
//  result_hi  out  N        MUL high half / DIV remainder; 0 otherwise
//  flag_v, flag_c, flag_n, flag_z  out 1 each  overflow, carry, negative, zero
//  op_err     out  1        illegal opcode (or DIV with ALU_MC_DIV_EN off)
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1 once rst_n high; out_valid=0; all outputs 0. Async assert
//   mid-operation aborts it; no result is ever produced for the aborted op.
//  Opcodes: 0 ADD a+b+cin, 1 SUB a-b, 2 MUL unsigned, 3 DIV unsigned, 4 AND, 5 OR, 6 XOR,
//   7 NOR, 8 NAND, 9 XNOR, 10-15 EQ/NEQ/LT/LTE/GT/GTE signed (result 1 or 0), 16 SLL, 17 SRL,
//   18 ROL, 19 ROR; 20-31 illegal -> result 0, op_err=1.
//  Handshake: accept on in_valid&&in_ready; operands/op captured at accept.
//   in_ready = (state==IDLE) || (state==DONE && out_ready): back-to-back accepts allowed.
//   Outputs stable while out_valid && !out_ready; out_valid drops after transfer unless a new
//   single-cycle op is accepted the same cycle.
//  FSM: IDLE -accept 1-cycle op-> DONE; IDLE -accept MUL/DIV-> BUSY; BUSY -count==0-> DONE;
//   DONE -out_ready & no accept-> IDLE; DONE -out_ready & accept-> DONE or BUSY.
//  Latency (accept at edge T): single-cycle ops out_valid at T+1; MUL/DIV at T+N+1
//   (N iterations, one bit per cycle, down-counter N-1..0).
//  MUL: shift-add, 2N-bit product; result=low N, result_hi=high N; flag_c=|result_hi.
//  DIV: restoring; result=quotient, result_hi=remainder. b==0 -> result all-ones,
//   result_hi=a, flag_v=1, still takes N cycles.
//  Flags: ADD/SUB: C=carry-out (SUB: C=1 means no borrow), V=signed overflow.
//   All ops: N=result[N-1], Z=(result==0). V=C=0 for all other ops (except above).
//  Shifts: amount b[SHAMT_W-1:0]; amount 0 passes a; rotates wrap modulo N.
// CONFIGURATION
//  ALU_MC_DIV_EN defined: DIV as above (iterative datapath handles both MUL and DIV).
//  Undefined: no divide hardware; DIV completes as a single-cycle op, result=0, result_hi=0,
//   op_err=1, flags V=C=0, Z=1.
// STRUCTURE
//  alu_pkg: alu_op_e (5-bit enum), alu_state_e {IDLE,BUSY,DONE}, alu_flags_t struct {v,c,n,z},
//   is_multicycle() function.
//  Sub-module alu_iter_muldiv: N-cycle shift-add / restoring-divide datapath with start/done;
//   divide path inside `ifdef ALU_MC_DIV_EN. Top holds FSM, 1-cycle ops, output registers.
// TESTING (N=32)
//  ADD a=7FFFFFFF b=1 cin=0 -> result 80000000, V=1 C=0 N=1 Z=0, out_valid at T+1.
//  SUB a=5 b=5 -> result 0, Z=1 C=1 V=0; LT a=FFFFFFFF b=1 -> result 1.
//  MUL a=FFFFFFFF b=2 -> result FFFFFFFE, result_hi 1, C=1; out_valid exactly T+33.
//  DIV a=100 b=7 -> result 24, result_hi 4; DIV b=0 a=9 -> result FFFFFFFF, hi 9, V=1;
//   with ALU_MC_DIV_EN off -> result 0, op_err=1 at T+1.
//  ROR a=00000001 b=1 -> 80000000; SLL b=32 -> amount 0, result=a; op=25 -> op_err=1, result 0.
//  Backpressure: hold out_ready=0 5 cycles -> outputs stable, in_ready=0; then back-to-back
//   ADDs with out_ready=1 -> one result per cycle; rst_n low mid-MUL -> out_valid 0, IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states, flag bundle, op classification.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a. ALU_MC_DIV_EN selects whether DIV is iterative or rejected as illegal.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_MUL  = 5'd2,
        OP_DIV  = 5'd3,
        OP_AND  = 5'd4,
        OP_OR   = 5'd5,
        OP_XOR  = 5'd6,
        OP_NOR  = 5'd7,
        OP_NAND = 5'd8,
        OP_XNOR = 5'd9,
        OP_EQ   = 5'd10,
        OP_NEQ  = 5'd11,
        OP_LT   = 5'd12,
        OP_LTE  = 5'd13,
        OP_GT   = 5'd14,
        OP_GTE  = 5'd15,
        OP_SLL  = 5'd16,
        OP_SRL  = 5'd17,
        OP_ROL  = 5'd18,
        OP_ROR  = 5'd19
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } alu_flags_t;

    // Ops that go through the iterative datapath; without divide hardware DIV stays single-cycle.
    function automatic logic is_multicycle(input logic [4:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle (macro ALU_MC_DIV_EN adds divide).
// Latency: operands loaded on start_i, done_o asserted N cycles later with the final step shown on lo_o/hi_o.
// Backpressure: none; the caller only starts a new op when idle, the final step is presented combinationally.
module alu_iter_muldiv #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
`ifdef ALU_MC_DIV_EN
    input  logic         is_div_i,
`endif
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         done_o,
    output logic [N-1:0] lo_o,
    output logic [N-1:0] hi_o
);

    localparam int CW = $clog2(N);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  hi_q, lo_q, opnd_q;
    logic [N-1:0]  hi_d, lo_d;
    logic [N:0]    sum;
`ifdef ALU_MC_DIV_EN
    logic          div_q;
    logic [N:0]    rem_sh;
    logic [N-1:0]  rem_sub;
`endif

    // One iteration: multiply adds the multiplicand when the low bit is set, divide trial-subtracts.
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
        hi_d = sum[N:1];
        lo_d = {sum[0], lo_q[N-1:1]};
`ifdef ALU_MC_DIV_EN
        rem_sh  = {hi_q, lo_q[N-1]};
        rem_sub = rem_sh[N-1:0] - opnd_q;
        if (div_q) begin
            // Divisor 0 always "fits": quotient becomes all-ones and the dividend shifts into the remainder.
            if (rem_sh >= {1'b0, opnd_q}) begin
                hi_d = rem_sub;
                lo_d = {lo_q[N-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[N-1:0];
                lo_d = {lo_q[N-2:0], 1'b0};
            end
        end
`endif
    end

    assign done_o = busy_q && (cnt_q == '0);
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    // Operand load on start, then N iterations counted down from N-1 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
`ifdef ALU_MC_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(N - 1);
            hi_q   <= '0;
`ifdef ALU_MC_DIV_EN
            div_q  <= is_div_i;
            lo_q   <= is_div_i ? a_i : b_i;
            opnd_q <= is_div_i ? b_i : a_i;
`else
            lo_q   <= b_i;
            opnd_q <= a_i;
`endif
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result/flags and valid/ready handshake (macro ALU_MC_DIV_EN enables iterative DIV).
// Latency: single-cycle ops valid the cycle after accept; MUL/DIV valid N+1 cycles after accept.
// Backpressure: result held stable until out_ready; a new op is accepted in the same cycle as the transfer.
module alu_mc
    import alu_pkg::*;
#(
    parameter int N       = 32,
    parameter int SHAMT_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         flag_v,
    output logic         flag_c,
    output logic         flag_n,
    output logic         flag_z,
    output logic         op_err
);

    alu_state_e   state_q;
    logic [N-1:0] result_q, result_hi_q;
    alu_flags_t   flags_q;
    logic         op_err_q;

    logic         accept, start_mc;
    logic [N-1:0] sc_res;
    alu_flags_t   sc_flags;
    logic         sc_err;
    logic [N:0]   add_w;
    logic [2*N-1:0] rot_w;
    logic [SHAMT_W-1:0] shamt;

    logic         md_done;
    logic [N-1:0] md_lo, md_hi;
    alu_flags_t   mc_flags;
`ifdef ALU_MC_DIV_EN
    logic         div_q, dz_q;
`endif

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mc  = accept && is_multicycle(op);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_v    = flags_q.v;
    assign flag_c    = flags_q.c;
    assign flag_n    = flags_q.n;
    assign flag_z    = flags_q.z;
    assign op_err    = op_err_q;
    assign shamt     = b[SHAMT_W-1:0];

    alu_iter_muldiv #(.N(N)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_mc),
`ifdef ALU_MC_DIV_EN
        .is_div_i (op == OP_DIV),
`endif
        .a_i      (a),
        .b_i      (b),
        .done_o   (md_done),
        .lo_o     (md_lo),
        .hi_o     (md_hi)
    );

    // Single-cycle result and flags, computed from the live operands at accept time.
    always_comb begin
        sc_res   = '0;
        sc_flags = '0;
        sc_err   = 1'b0;
        add_w    = '0;
        rot_w    = '0;
        case (alu_op_e'(op))
            OP_ADD: begin
                add_w      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
                sc_res     = add_w[N-1:0];
                sc_flags.c = add_w[N];
                sc_flags.v = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1: set means no borrow.
                add_w      = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
                sc_res     = add_w[N-1:0];
                sc_flags.c = add_w[N];
                sc_flags.v = (a[N-1] != b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_NAND: sc_res = ~(a & b);
            OP_XNOR: sc_res = ~(a ^ b);
            OP_EQ:   sc_res = {{(N-1){1'b0}}, (a == b)};
            OP_NEQ:  sc_res = {{(N-1){1'b0}}, (a != b)};
            OP_LT:   sc_res = {{(N-1){1'b0}}, ($signed(a) <  $signed(b))};
            OP_LTE:  sc_res = {{(N-1){1'b0}}, ($signed(a) <= $signed(b))};
            OP_GT:   sc_res = {{(N-1){1'b0}}, ($signed(a) >  $signed(b))};
            OP_GTE:  sc_res = {{(N-1){1'b0}}, ($signed(a) >= $signed(b))};
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_ROL: begin
                rot_w  = {a, a} << shamt;
                sc_res = rot_w[2*N-1:N];
            end
            OP_ROR: begin
                rot_w  = {a, a} >> shamt;
                sc_res = rot_w[N-1:0];
            end
            OP_MUL:  sc_res = '0;
`ifdef ALU_MC_DIV_EN
            OP_DIV:  sc_res = '0;
`endif
            // Opcodes 20-31, and DIV when there is no divide hardware.
            default: sc_err = 1'b1;
        endcase
        sc_flags.n = sc_res[N-1];
        sc_flags.z = (sc_res == '0);
    end

    // Flags for the iterative result: MUL carry marks a non-zero high half, DIV overflow marks divide-by-zero.
    always_comb begin
        mc_flags   = '0;
        mc_flags.n = md_lo[N-1];
        mc_flags.z = (md_lo == '0);
`ifdef ALU_MC_DIV_EN
        if (div_q) begin
            mc_flags.v = dz_q;
        end else begin
            mc_flags.c = |md_hi;
        end
`else
        mc_flags.c = |md_hi;
`endif
    end

    // Control FSM with registered outputs; an accept always wins, then iteration completion, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            op_err_q    <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q       <= 1'b0;
            dz_q        <= 1'b0;
`endif
        end else if (accept) begin
            if (start_mc) begin
                state_q <= BUSY;
`ifdef ALU_MC_DIV_EN
                div_q   <= (op == OP_DIV);
                dz_q    <= (b == '0);
`endif
            end else begin
                state_q     <= DONE;
                result_q    <= sc_res;
                result_hi_q <= '0;
                flags_q     <= sc_flags;
                op_err_q    <= sc_err;
            end
        end else if ((state_q == BUSY) && md_done) begin
            state_q     <= DONE;
            result_q    <= md_lo;
            result_hi_q <= md_hi;
            flags_q     <= mc_flags;
            op_err_q    <= 1'b0;
        end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed table, handshake corner sequences, random ops vs. a reference model.
// Latency: every op is timed from its accept edge to the first cycle out_valid is seen.
// Backpressure: exercises held results, back-to-back accepts and reset during a multiply.
module tb_alu_mc;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result, result_hi;
    logic         flag_v, flag_c, flag_n, flag_z, op_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic [31:0] hi;
        logic        v, c, n, z, err;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    alu_mc #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flag_v    (flag_v),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                                input logic vc, input logic [31:0] r, input logic [31:0] h,
                                input logic fv, input logic fc, input logic fn, input logic fz,
                                input logic e, input int l);
        vec_t t;
        t.op = o; t.a = va; t.b = vb; t.cin = vc; t.res = r; t.hi = h;
        t.v = fv; t.c = fc; t.n = fn; t.z = fz; t.err = e; t.lat = l;
        return t;
    endfunction

    // Reference behaviour written from the opcode definitions with plain integer arithmetic.
    function automatic vec_t model(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb, input logic vc);
        vec_t t;
        longint sa, sb, ss;
        logic [63:0] p;
        int s;
        t.op = o; t.a = va; t.b = vb; t.cin = vc;
        t.res = '0; t.hi = '0; t.v = 0; t.c = 0; t.err = 0; t.lat = 1;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        s  = int'(vb[4:0]);
        case (o)
            5'd0: begin
                p = {32'd0, va} + {32'd0, vb} + {63'd0, vc};
                t.res = p[31:0];
                t.c = (p >= 64'h1_0000_0000);
                ss = sa + sb + longint'(vc);
                t.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            5'd1: begin
                t.res = va - vb;
                t.c = (va >= vb);
                ss = sa - sb;
                t.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            5'd2: begin
                p = {32'd0, va} * {32'd0, vb};
                t.res = p[31:0];
                t.hi = p[63:32];
                t.c = (t.hi != 0);
                t.lat = 33;
            end
            5'd3: begin
`ifdef ALU_MC_DIV_EN
                t.lat = 33;
                if (vb == 0) begin
                    t.res = 32'hFFFF_FFFF; t.hi = va; t.v = 1;
                end else begin
                    t.res = va / vb; t.hi = va % vb;
                end
`else
                t.err = 1;
`endif
            end
            5'd4: t.res = va & vb;
            5'd5: t.res = va | vb;
            5'd6: t.res = va ^ vb;
            5'd7: t.res = ~(va | vb);
            5'd8: t.res = ~(va & vb);
            5'd9: t.res = ~(va ^ vb);
            5'd10: t.res = (sa == sb) ? 1 : 0;
            5'd11: t.res = (sa != sb) ? 1 : 0;
            5'd12: t.res = (sa <  sb) ? 1 : 0;
            5'd13: t.res = (sa <= sb) ? 1 : 0;
            5'd14: t.res = (sa >  sb) ? 1 : 0;
            5'd15: t.res = (sa >= sb) ? 1 : 0;
            5'd16: t.res = va << s;
            5'd17: t.res = va >> s;
            5'd18: t.res = (s == 0) ? va : ((va << s) | (va >> (32 - s)));
            5'd19: t.res = (s == 0) ? va : ((va >> s) | (va << (32 - s)));
            default: t.err = 1;
        endcase
        t.n = t.res[31];
        t.z = (t.res == 0);
        return t;
    endfunction

    // Issue one op from idle, time it, compare all outputs, then drain it.
    task automatic run_op(input vec_t e, input string name);
        int lat;
        op = e.op; a = e.a; b = e.b; cin = e.cin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " out"}, {result, result_hi, flag_v, flag_c, flag_n, flag_z, op_err},
              {e.res, e.hi, e.v, e.c, e.n, e.z, e.err});
        check({name, " lat"}, lat, e.lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        vec_t e;

        //               op     a             b             cin res           hi            v  c  n  z  err lat
        tbl.push_back(mk(5'd0,  32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 32'h0,       1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(5'd0,  32'hFFFFFFFF, 32'h00000000, 1, 32'h00000000, 32'h0,       0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(5'd1,  32'h00000005, 32'h00000005, 0, 32'h00000000, 32'h0,       0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(5'd1,  32'h00000003, 32'h00000005, 0, 32'hFFFFFFFE, 32'h0,       0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(5'd1,  32'h80000000, 32'h00000001, 0, 32'h7FFFFFFF, 32'h0,       1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(5'd12, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000001, 32'h0,       0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(5'd15, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 32'h0,       0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(5'd13, 32'h80000000, 32'h7FFFFFFF, 0, 32'h00000001, 32'h0,       0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(5'd10, 32'h00000005, 32'h00000005, 0, 32'h00000001, 32'h0,       0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(5'd2,  32'hFFFFFFFF, 32'h00000002, 0, 32'hFFFFFFFE, 32'h1,       0, 1, 1, 0, 0, 33));
        tbl.push_back(mk(5'd2,  32'h00010000, 32'h00010000, 0, 32'h00000000, 32'h1,       0, 1, 0, 1, 0, 33));
`ifdef ALU_MC_DIV_EN
        tbl.push_back(mk(5'd3,  32'h00000100, 32'h00000007, 0, 32'h00000024, 32'h4,       0, 0, 0, 0, 0, 33));
        tbl.push_back(mk(5'd3,  32'h00000009, 32'h00000000, 0, 32'hFFFFFFFF, 32'h9,       1, 0, 1, 0, 0, 33));
`else
        tbl.push_back(mk(5'd3,  32'h00000100, 32'h00000007, 0, 32'h00000000, 32'h0,       0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(5'd3,  32'h00000009, 32'h00000000, 0, 32'h00000000, 32'h0,       0, 0, 0, 1, 1, 1));
`endif
        tbl.push_back(mk(5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 32'h0,       0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(5'd7,  32'h00000000, 32'h00000000, 0, 32'hFFFFFFFF, 32'h0,       0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(5'd19, 32'h00000001, 32'h00000001, 0, 32'h80000000, 32'h0,       0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(5'd18, 32'h80000001, 32'h00000004, 0, 32'h00000018, 32'h0,       0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(5'd16, 32'h12345678, 32'h00000020, 0, 32'h12345678, 32'h0,       0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(5'd17, 32'h80000000, 32'h0000001F, 0, 32'h00000001, 32'h0,       0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(5'd25, 32'h12345678, 32'h00000003, 0, 32'h00000000, 32'h0,       0, 0, 0, 1, 1, 1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset in_ready", in_ready, 1'b1);
        check("reset outputs", {out_valid, result, result_hi, flag_v, flag_c, flag_n, flag_z, op_err}, '0);

        // Directed table
        foreach (tbl[i]) begin
            run_op(tbl[i], $sformatf("tbl%0d op%0d", i, tbl[i].op));
        end

        // Backpressure: hold the result for 5 cycles while another op is offered
        op = 5'd0; a = 32'd100; b = 32'd23; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 a = 32'd999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold out_valid", out_valid, 1'b1);
            check("hold result", result, 32'd123);
            check("hold in_ready", in_ready, 1'b0);
        end
        // Back-to-back ADDs, one result per cycle
        out_ready = 1'b1; a = 32'd200; b = 32'd0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("b2b out_valid", out_valid, 1'b1);
            check("b2b result", result, 32'(200 + k));
            check("b2b in_ready", in_ready, 1'b1);
            if (k < 3) a = 32'(200 + k + 1);
            else in_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("b2b drain out_valid", out_valid, 1'b0);
        out_ready = 1'b0;

        // Reset asserted in the middle of a multiply
        op = 5'd2; a = 32'd3; b = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("busy in_ready", in_ready, 1'b0);
        check("busy out_valid", out_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        check("abort no result", seen, 0);
        check("abort in_ready", in_ready, 1'b1);
        check("abort outputs", {result, result_hi, op_err}, '0);
        run_op(model(5'd2, 32'd7, 32'd9, 1'b0), "post-abort mul");

        // Random ops against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [4:0]  ro;
            logic [31:0] ra, rb;
            ro = 5'($urandom_range(0, 31));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            e = model(ro, ra, rb, 1'($urandom_range(0, 1)));
            run_op(e, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
